// File: rtl/laser_trip_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : laser_trip_ctrl
//  Purpose  : Paces laser-sensor ADC sampling, calibrates a baseline light
//             level on arming, then watches for the beam being broken using
//             a fixed margin below the baseline and a consecutive-sample
//             debounce. It also latches sensor faults (response timeout or
//             a baseline that is too dim).
//  Options  : LASER_FAIL_SECURE_EN - when defined, entering FAULT also
//             raises laser_triggered so a dead sensor still trips the alarm.
//  Revision : 1.0 - initial release
// ============================================================================
module laser_trip_ctrl #(
  parameter int ADC_W        = 12,
  parameter int CAL_LOG2     = 4,
  parameter int DEBOUNCE     = 4,
  parameter int MARGIN       = 256,
  parameter int MIN_BASELINE = 1024,
  parameter int SAMPLE_DIV   = 50000,
  parameter int TIMEOUT      = 1000
) (
  input  logic             clock,
  input  logic             rst,
  input  logic [1:0]       system_state,
  output logic             sample_req,
  input  logic             sample_valid,
  input  logic [ADC_W-1:0] sample_data,
  output logic             laser_triggered,
  output logic             fault,
  output logic [ADC_W-1:0] baseline,
  output logic [2:0]       ctrl_state
);

  localparam int DIV_W = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
  localparam int TO_W  = $clog2(TIMEOUT + 1);
  localparam int CNT_W = CAL_LOG2 + 1;
  localparam int DB_W  = $clog2(DEBOUNCE + 1);
  localparam int ACC_W = ADC_W + CAL_LOG2;

  localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [TO_W-1:0]  TO_MAX     = TO_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CAL_LAST   = CNT_W'((1 << CAL_LOG2) - 1);
  localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DEBOUNCE - 1);
  localparam logic [ADC_W-1:0] MARGIN_V   = ADC_W'(MARGIN);
  localparam logic [ADC_W-1:0] MIN_V      = ADC_W'(MIN_BASELINE);

  localparam logic [1:0] SYS_IDLE = 2'b00;
  localparam logic [1:0] SYS_SET  = 2'b01;

`ifdef LASER_FAIL_SECURE_EN
  localparam logic FAIL_SECURE = 1'b1;
`else
  localparam logic FAIL_SECURE = 1'b0;
`endif

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CAL     = 3'd1,
    ST_MONITOR = 3'd2,
    ST_TRIPPED = 3'd3,
    ST_FAULT   = 3'd4
  } state_t;

  state_t           state;
  logic [DIV_W-1:0] div_cnt;
  logic             outstanding;
  logic [TO_W-1:0]  out_cnt;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cal_cnt;
  logic [DB_W-1:0]  below_cnt;

  logic             accept;
  logic [ACC_W-1:0] acc_next;
  logic [ADC_W-1:0] cal_baseline;
  logic [ADC_W-1:0] threshold;
  logic             below_hit;

  // A sample only counts when it answers a request we actually issued
  assign accept       = outstanding & sample_valid;
  assign acc_next     = acc + {{CAL_LOG2{1'b0}}, sample_data};
  assign cal_baseline = acc_next[ACC_W-1:CAL_LOG2];
  assign threshold    = baseline - MARGIN_V;
  assign below_hit    = sample_data < threshold;
  assign ctrl_state   = state;

  // Controller state, sample pacing, request tracking and registered outputs
  always_ff @(posedge clock) begin
    if (rst) begin
      state           <= ST_IDLE;
      sample_req      <= 1'b0;
      laser_triggered <= 1'b0;
      fault           <= 1'b0;
      baseline        <= '0;
      div_cnt         <= '0;
      outstanding     <= 1'b0;
      out_cnt         <= '0;
      acc             <= '0;
      cal_cnt         <= '0;
      below_cnt       <= '0;
    end else if (system_state == SYS_IDLE) begin
      // Abort beats everything; any sample arriving now is dropped and
      // the last baseline is kept for reporting.
      state           <= ST_IDLE;
      sample_req      <= 1'b0;
      laser_triggered <= 1'b0;
      fault           <= 1'b0;
      div_cnt         <= '0;
      outstanding     <= 1'b0;
      out_cnt         <= '0;
      acc             <= '0;
      cal_cnt         <= '0;
      below_cnt       <= '0;
    end else begin
      sample_req <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (system_state == SYS_SET) begin
            state       <= ST_CAL;
            div_cnt     <= DIV_RELOAD;
            outstanding <= 1'b0;
            out_cnt     <= '0;
            acc         <= '0;
            cal_cnt     <= '0;
            below_cnt   <= '0;
          end
        end

        ST_CAL, ST_MONITOR: begin
          if (div_cnt == '0) begin
            div_cnt <= DIV_RELOAD;
          end else begin
            div_cnt <= div_cnt - 1'b1;
          end

          // out_cnt counts the request cycle as 1, so the fault lands
          // TIMEOUT cycles after the request pulse.
          if (!outstanding) begin
            if (div_cnt == '0) begin
              sample_req  <= 1'b1;
              outstanding <= 1'b1;
              out_cnt     <= TO_W'(1);
            end
          end else if (accept) begin
            outstanding <= 1'b0;
            out_cnt     <= '0;
          end else if (out_cnt == TO_MAX) begin
            state           <= ST_FAULT;
            fault           <= 1'b1;
            laser_triggered <= FAIL_SECURE;
            outstanding     <= 1'b0;
            out_cnt         <= '0;
          end else begin
            out_cnt <= out_cnt + 1'b1;
          end

          if (accept && state == ST_CAL) begin
            acc     <= acc_next;
            cal_cnt <= cal_cnt + 1'b1;
            if (cal_cnt == CAL_LAST) begin
              baseline <= cal_baseline;
              if (cal_baseline < MIN_V) begin
                state           <= ST_FAULT;
                fault           <= 1'b1;
                laser_triggered <= FAIL_SECURE;
              end else begin
                state <= ST_MONITOR;
              end
            end
          end

          if (accept && state == ST_MONITOR) begin
            if (below_hit) begin
              below_cnt <= below_cnt + 1'b1;
              if (below_cnt == DB_LAST) begin
                state           <= ST_TRIPPED;
                laser_triggered <= 1'b1;
              end
            end else begin
              below_cnt <= '0;
            end
          end
        end

        ST_TRIPPED: begin
          laser_triggered <= 1'b1;
        end

        ST_FAULT: begin
          fault <= 1'b1;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_laser_trip_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_laser_trip_ctrl
//  Purpose  : Directed scoreboard bench for laser_trip_ctrl. The stimulus
//             thread queues every output event it expects (cycle, request
//             pulse, state, flags, baseline); a monitor thread records each
//             observed event and compares it with the head of the queue.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_laser_trip_ctrl;

  localparam int ADC_W        = 12;
  localparam int CAL_LOG2     = 2;
  localparam int DEBOUNCE     = 3;
  localparam int MARGIN       = 256;
  localparam int MIN_BASELINE = 1024;
  localparam int SAMPLE_DIV   = 4;
  localparam int TIMEOUT      = 8;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CAL   = 3'd1;
  localparam logic [2:0] S_MON   = 3'd2;
  localparam logic [2:0] S_TRIP  = 3'd3;
  localparam logic [2:0] S_FAULT = 3'd4;

`ifdef LASER_FAIL_SECURE_EN
  localparam logic FS_TRIG = 1'b1;
`else
  localparam logic FS_TRIG = 1'b0;
`endif

  logic             clock = 1'b0;
  logic             rst = 1'b1;
  logic [1:0]       system_state = 2'b00;
  logic             sample_req;
  logic             sample_valid = 1'b0;
  logic [ADC_W-1:0] sample_data = '0;
  logic             laser_triggered;
  logic             fault;
  logic [ADC_W-1:0] baseline;
  logic [2:0]       ctrl_state;

  laser_trip_ctrl #(
    .ADC_W        (ADC_W),
    .CAL_LOG2     (CAL_LOG2),
    .DEBOUNCE     (DEBOUNCE),
    .MARGIN       (MARGIN),
    .MIN_BASELINE (MIN_BASELINE),
    .SAMPLE_DIV   (SAMPLE_DIV),
    .TIMEOUT      (TIMEOUT)
  ) dut (
    .clock           (clock),
    .rst             (rst),
    .system_state    (system_state),
    .sample_req      (sample_req),
    .sample_valid    (sample_valid),
    .sample_data     (sample_data),
    .laser_triggered (laser_triggered),
    .fault           (fault),
    .baseline        (baseline),
    .ctrl_state      (ctrl_state)
  );

  always #5 clock = ~clock;

  typedef struct {
    int         cyc;
    logic       req;
    logic [2:0] st;
    logic       trig;
    logic       flt;
    logic [11:0] bl;
  } ev_t;

  ev_t   exp_q[$];
  string name_q[$];

  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  logic mon_en = 1'b0;
  logic snap = 1'b0;
  logic drain = 1'b0;
  logic drained = 1'b0;

  // Expected output tuple as the stimulus believes it to be
  logic [2:0]  e_st = S_IDLE;
  logic        e_trig = 1'b0;
  logic        e_flt = 1'b0;
  logic [11:0] e_bl = '0;
  int          nreq = 0;

  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: one record per cycle with any output activity
  logic [2:0]  p_st;
  logic        p_trig, p_flt;
  logic [11:0] p_bl;

  always @(negedge clock) begin
    ev_t   e;
    string n;
    logic  chg;
    chg = (ctrl_state !== p_st) || (laser_triggered !== p_trig) ||
          (fault !== p_flt) || (baseline !== p_bl);
    if (mon_en && (chg || sample_req === 1'b1 || snap)) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_event: got cyc=%0d req=%0b st=%0d trig=%0b fault=%0b bl=%0d, required no event",
                 cyc, sample_req, ctrl_state, laser_triggered, fault, baseline);
      end else begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        if (e.cyc != cyc || e.req !== sample_req || e.st !== ctrl_state ||
            e.trig !== laser_triggered || e.flt !== fault || e.bl !== baseline) begin
          miscompares++;
          $display("FAIL %s: got cyc=%0d req=%0b st=%0d trig=%0b fault=%0b bl=%0d, required cyc=%0d req=%0b st=%0d trig=%0b fault=%0b bl=%0d",
                   n, cyc, sample_req, ctrl_state, laser_triggered, fault, baseline,
                   e.cyc, e.req, e.st, e.trig, e.flt, e.bl);
        end
      end
    end
    if (drain && !drained) begin
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        vectors++;
        miscompares++;
        $display("FAIL %s: got no event, required event at cyc=%0d st=%0d", n, e.cyc, e.st);
      end
      drained <= 1'b1;
    end
    p_st   <= ctrl_state;
    p_trig <= laser_triggered;
    p_flt  <= fault;
    p_bl   <= baseline;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  task automatic expect_ev(input string n, input int c, input logic r);
    ev_t e;
    e.cyc  = c;
    e.req  = r;
    e.st   = e_st;
    e.trig = e_trig;
    e.flt  = e_flt;
    e.bl   = e_bl;
    exp_q.push_back(e);
    name_q.push_back(n);
  endtask

  task automatic snap_check(input string n);
    expect_ev(n, cyc, 1'b0);
    snap = 1'b1;
    tick();
    snap = 1'b0;
  endtask

  task automatic arm();
    e_st = S_CAL; e_trig = 1'b0; e_flt = 1'b0;
    expect_ev("arm", cyc + 1, 1'b0);
    system_state = 2'b01;
    tick();
    nreq = cyc + SAMPLE_DIV;
  endtask

  task automatic abort(input string n);
    system_state = 2'b00;
    e_st = S_IDLE; e_trig = 1'b0; e_flt = 1'b0;
    expect_ev(n, cyc + 1, 1'b0);
    tick();
  endtask

  // Expect the next request, answer it the following cycle
  task automatic give(input string n, input logic [11:0] d);
    expect_ev({n, "_req"}, nreq, 1'b1);
    wait_until(nreq + 1);
    sample_valid = 1'b1;
    sample_data  = d;
    tick();
    sample_valid = 1'b0;
    nreq += SAMPLE_DIV;
  endtask

  task automatic calibrate(input string n, input logic [11:0] s0, input logic [11:0] s1,
                           input logic [11:0] s2, input logic [11:0] s3,
                           input logic [11:0] bl, input logic [2:0] st);
    give(n, s0); give(n, s1); give(n, s2); give(n, s3);
    e_bl = bl;
    e_st = st;
    if (st == S_FAULT) begin
      e_flt  = 1'b1;
      e_trig = FS_TRIG;
    end
    expect_ev({n, "_done"}, cyc, 1'b0);
  endtask

  task automatic mon(input string n, input logic [11:0] d, input logic trips);
    give(n, d);
    if (trips) begin
      e_st = S_TRIP; e_trig = 1'b1;
      expect_ev({n, "_trip"}, cyc, 1'b0);
    end
  endtask

  initial begin
    repeat (3) tick();
    rst = 1'b0;
    mon_en = 1'b1;
    snap_check("reset");

    // Calibration: baseline floor(8006/4) = 2001, first request 4 cycles after entry
    arm();
    calibrate("cal", 12'd2000, 12'd2001, 12'd2002, 12'd2003, 12'd2001, S_MON);

    // Threshold 1745: equal samples never count, 1800 clears, three 1744 in a row trip
    mon("eq1", 12'd1745, 1'b0);
    mon("eq2", 12'd1745, 1'b0);
    mon("eq3", 12'd1745, 1'b0);
    mon("d1",  12'd1744, 1'b0);
    mon("d2",  12'd1744, 1'b0);
    mon("d3",  12'd1800, 1'b0);
    mon("d4",  12'd1744, 1'b0);
    mon("d5",  12'd1744, 1'b0);
    mon("d6",  12'd1744, 1'b1);

    // Latched trip survives TRIGGER/ALERT, with no further requests
    system_state = 2'b10;
    repeat (6) tick();
    system_state = 2'b11;
    repeat (6) tick();
    snap_check("trip_hold");
    abort("trip_abort");

    // Spurious strobe and TRIGGER/ALERT while idle change nothing
    sample_valid = 1'b1; sample_data = 12'd100;
    tick();
    sample_valid = 1'b0;
    system_state = 2'b10;
    repeat (3) tick();
    system_state = 2'b11;
    repeat (3) tick();
    snap_check("idle_spurious");
    system_state = 2'b00;
    tick();

    // Dim baseline faults
    arm();
    calibrate("lowbl", 12'd1000, 12'd1000, 12'd1000, 12'd1000, 12'd1000, S_FAULT);
    repeat (10) tick();
    abort("fault_abort");

    // Withheld response: fault TIMEOUT cycles after the request, no second request
    arm();
    calibrate("cal2", 12'd2000, 12'd2001, 12'd2002, 12'd2003, 12'd2001, S_MON);
    expect_ev("to_req", nreq, 1'b1);
    e_st = S_FAULT; e_flt = 1'b1; e_trig = FS_TRIG;
    expect_ev("timeout", nreq + TIMEOUT, 1'b0);
    wait_until(nreq + TIMEOUT + 6);
    abort("to_abort");

    // Abort mid-calibration with a sample in the abort cycle
    arm();
    give("ab1", 12'd3000);
    give("ab2", 12'd3000);
    expect_ev("ab3_req", nreq, 1'b1);
    wait_until(nreq + 1);
    sample_valid = 1'b1; sample_data = 12'd3000;
    system_state = 2'b00;
    e_st = S_IDLE;
    expect_ev("ab_abort", cyc + 1, 1'b0);
    tick();
    sample_valid = 1'b0;

    // Rearm needs a full four-sample calibration: floor(4806/4) = 1201
    arm();
    calibrate("recal", 12'd1200, 12'd1201, 12'd1202, 12'd1203, 12'd1201, S_MON);
    abort("end_abort");

    repeat (4) tick();
    drain = 1'b1;
    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
